seq_detect_sched: RTL and testbench
===================================

// Module: seq_detect_sched
// PURPOSE
//   Shares one bit-serial overlapping "1011" sequence detector between NUM_REQ word-level requesters.
//   Picks a requester by round-robin and clears the detector.
//   Shifts the granted word into the detector MSB-first and counts seq_seen pulses.
//   Returns {requester id, match count} on a valid/ready result port.
//   Sits between the requester fabric and the detector instance in the top level.
// PARAMETERS
//   NUM_REQ  4   number of requesters (>=2)
//   WORD_W   16  bits per request word, shifted MSB-first
//   CNT_W    5   match counter width; saturates at 2**CNT_W-1
//   ID_W     2   requester id width; must satisfy 2**ID_W >= NUM_REQ
// PORTS
//   clk        in   1               rising-edge clock
//   reset      in   1               asynchronous, active-high reset
//   req_valid  in   NUM_REQ         per-requester request valid
//   req_data   in   NUM_REQ*WORD_W  request words; requester i owns bits [i*WORD_W +: WORD_W]
//   req_ready  out  NUM_REQ         one-hot accept, combinational from state and req_valid
//   det_bit    out  1               serial bit to the detector input
//   det_reset  out  1               detector clear (detector resets synchronously)
//   det_seen   in   1               detector match flag; high the cycle after the 4th pattern bit
//   res_valid  out  1               result valid
//   res_id     out  ID_W            index of the requester the result belongs to
//   res_count  out  CNT_W           number of matches in that word
//   res_ready  in   1               result consumer ready
// BEHAVIOUR
//   Reset (async, any state): FSM goes to IDLE.
//   Reset values: rr pointer = 0, count = 0, res_valid = 0, res_id = 0, res_count = 0, req_ready = 0, det_bit = 0.
//   det_reset = reset | (state==CLEAR), so a mid-operation reset also clears the detector.
//   FSM IDLE -> CLEAR -> SHIFT -> DRAIN -> DONE -> IDLE.
//   IDLE
//     - If any req_valid: grant g = first valid index at or after rr pointer, wrapping modulo NUM_REQ.
//     - req_ready[g] = 1 in this cycle; capture word and g; rr pointer <= (g+1) mod NUM_REQ.
//     - Count <= 0; go to CLEAR.
//     - No valid: stay in IDLE, req_ready = 0.
//   CLEAR: 1 cycle, det_reset = 1, det_bit = 0.
//   SHIFT: WORD_W cycles; det_bit = shift_reg MSB; shift left one bit per cycle; bit counter 0..WORD_W-1.
//   DRAIN: 1 cycle, det_bit = 0; catches the seq_seen produced by the last shifted bit.
//   Counting: in SHIFT and DRAIN, count <= count + det_seen, saturating at all-ones.
//   DONE: res_valid = 1; res_id and res_count held stable until res_valid & res_ready, then go to IDLE.
//   No new grant while a result is pending (backpressure propagates to requesters).
//   Latency: handshake in cycle T -> CLEAR T+1 -> SHIFT T+2..T+WORD_W+1 -> DRAIN T+WORD_W+2
//     -> res_valid first high in T+WORD_W+3 (19 cycles for WORD_W=16).
//   Back-to-back: res handshake in cycle D returns to IDLE at D+1; the next grant is possible in D+1.
//   Outside SHIFT, det_bit = 0; det_seen is ignored outside SHIFT/DRAIN.
//   req_data of non-granted requesters is never sampled. A requester dropping valid before its grant simply loses its turn.
// STRUCTURE
//   Shared package seq_sched_pkg:
//     - state encoding localparams: IDLE=0, CLEAR=1, SHIFT=2, DRAIN=3, DONE=4 (3-bit);
//     - pattern length constant PAT_LEN=4.
//   Sub-module rr_arbiter (NUM_REQ): inputs req, ptr, en; outputs one-hot grant and encoded index. Purely combinational.
//   The shift register, bit counter, match counter and FSM live in seq_detect_sched.
//   The detector is instantiated beside this block in the top level, not inside it.
// TESTING  (WORD_W=16, NUM_REQ=4; bench instantiates the real overlapping detector)
//   - req_valid=4'b0001, word 16'hB000 -> req_ready=0001 for one cycle; res_valid at T+19 with res_id=0, res_count=1.
//   - req1 word 16'hB6D0 (1011 0110 1101 0000) -> res_count=3 (overlapping matches); word 16'hFFFF -> res_count=0.
//   - req_valid=4'b0101 held, res_ready=1 -> grants in order 0,2,0,2.
//     - req_ready is never multi-hot.
//     - rr pointer after grant of 2 is 3, so the next grant wraps to 0.
//   - res_ready=0 for 10 cycles after res_valid -> res_valid, res_id, res_count stable; req_ready stays 0; the grant follows the release.
//   - Assert reset in the 5th SHIFT cycle -> immediately: res_valid=0, det_reset=1, req_ready=0.
//     After release, the next request yields the correct count with no stale matches.
//   - Word 16'hBBBB with CNT_W=1 -> res_count saturates at 1 without wrapping.

Source files
------------

// File: rtl/seq_sched_pkg.sv
// Shared definitions for the scheduled 1011 sequence-detector front end.
package seq_sched_pkg;

    // Raw FSM state encodings (3-bit)
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = S_IDLE,
        CLEAR = S_CLEAR,
        SHIFT = S_SHIFT,
        DRAIN = S_DRAIN,
        DONE  = S_DONE
    } state_t;

    // Length of the serial pattern recognised by the shared detector
    localparam int unsigned PAT_LEN = 4;

endpackage

// File: rtl/seq_detect_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx
);

    int unsigned cand;
    logic        found;

    // Scan requesters starting at ptr, wrapping, and take the first one asserted
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = (32'(ptr) + i) % NUM_REQ;
            if (en && !found && (|(req & (NUM_REQ'(1) << cand)))) begin
                found = 1'b1;
                grant = NUM_REQ'(1) << cand;
                idx   = ID_W'(cand);
            end
        end
    end

endmodule

// File: rtl/seq_detect_sched.sv
// Time-shares one serial 1011 detector between word-level requesters and
// returns {requester id, match count} per word on a valid/ready port.
module seq_detect_sched
    import seq_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WORD_W  = 16,
    parameter int unsigned CNT_W   = 5,
    parameter int unsigned ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*WORD_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      det_bit,
    output logic                      det_reset,
    input  logic                      det_seen,
    output logic                      res_valid,
    output logic [ID_W-1:0]           res_id,
    output logic [CNT_W-1:0]          res_count,
    input  logic                      res_ready
);

    localparam int unsigned       BCNT_W   = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [BCNT_W-1:0] BIT_LAST = BCNT_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    state_t              state;
    state_t              state_next;
    logic [ID_W-1:0]     rr_ptr;
    logic [WORD_W-1:0]   shift_reg;
    logic [BCNT_W-1:0]   bit_cnt;
    logic [CNT_W-1:0]    count;

    logic                arb_en;
    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     grant_idx;
    logic                grant_any;
    logic [WORD_W-1:0]   grant_word;
    logic [ID_W-1:0]     ptr_next;
    logic [CNT_W-1:0]    count_inc;
    logic                bit_last;

    // Arbitration only while idle and out of reset
    assign arb_en = (state == IDLE) && !reset;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .en    (arb_en),
        .grant (grant),
        .idx   (grant_idx)
    );

    assign grant_any  = |grant;
    assign req_ready  = grant;
    assign grant_word = WORD_W'(req_data >> (32'(grant_idx) * WORD_W));
    assign ptr_next   = ID_W'((32'(grant_idx) + 32'd1) % NUM_REQ);
    assign count_inc  = (det_seen && (count != CNT_MAX)) ? count + CNT_W'(1) : count;
    assign bit_last   = (bit_cnt == BIT_LAST);
    assign res_count  = count;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and detector drive; detector is also cleared while reset is high
    always_comb begin
        state_next = state;
        det_bit    = 1'b0;
        det_reset  = reset;
        unique case (state)
            IDLE: begin
                if (grant_any) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                det_reset  = 1'b1;
                state_next = SHIFT;
            end
            SHIFT: begin
                det_bit = shift_reg[WORD_W-1];
                if (bit_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                state_next = DONE;
            end
            DONE: begin
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: capture on grant, shift MSB-first, count matches, hold result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr    <= '0;
            shift_reg <= '0;
            bit_cnt   <= '0;
            count     <= '0;
            res_id    <= '0;
            res_valid <= 1'b0;
        end else begin
            res_valid <= (state_next == DONE);
            unique case (state)
                IDLE: begin
                    if (grant_any) begin
                        shift_reg <= grant_word;
                        res_id    <= grant_idx;
                        rr_ptr    <= ptr_next;
                        count     <= '0;
                        bit_cnt   <= '0;
                    end
                end
                SHIFT: begin
                    shift_reg <= shift_reg << 1;
                    bit_cnt   <= bit_cnt + BCNT_W'(1);
                    count     <= count_inc;
                end
                DRAIN: begin
                    count <= count_inc;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_detect_sched.sv
// Randomized self-checking bench for seq_detect_sched with two instances
// (CNT_W=5 and a saturating CNT_W=1), each feeding its own serial detector.
module tb_seq_detect_sched;
    import seq_sched_pkg::*;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned WORD_W  = 16;
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned ID_W    = 2;

    logic                      clk;
    logic                      reset;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*WORD_W-1:0] req_data;
    logic                      res_ready;

    logic [NUM_REQ-1:0] req_ready, req_ready_s;
    logic               det_bit, det_reset, det_seen;
    logic               det_bit_s, det_reset_s, det_seen_s;
    logic               res_valid, res_valid_s;
    logic [ID_W-1:0]    res_id, res_id_s;
    logic [CNT_W-1:0]   res_count;
    logic [0:0]         res_count_s;

    int n_checks = 0;
    int n_errors = 0;
    int rr_ptr_m = 0;

    seq_detect_sched #(.NUM_REQ(NUM_REQ), .WORD_W(WORD_W), .CNT_W(CNT_W), .ID_W(ID_W)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .det_bit(det_bit), .det_reset(det_reset), .det_seen(det_seen),
        .res_valid(res_valid), .res_id(res_id), .res_count(res_count), .res_ready(res_ready));

    seq_detect_sched #(.NUM_REQ(NUM_REQ), .WORD_W(WORD_W), .CNT_W(1), .ID_W(ID_W)) u_sat (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready_s),
        .det_bit(det_bit_s), .det_reset(det_reset_s), .det_seen(det_seen_s),
        .res_valid(res_valid_s), .res_id(res_id_s), .res_count(res_count_s), .res_ready(res_ready));

    // Overlapping 1011 detectors: remember the last three bits, flag a match a cycle later
    logic [2:0] hist_m, hist_s;
    always_ff @(posedge clk) begin
        if (det_reset) begin
            hist_m   <= '0;
            det_seen <= 1'b0;
        end else begin
            hist_m   <= {hist_m[1:0], det_bit};
            det_seen <= ({hist_m, det_bit} == 4'b1011);
        end
    end
    always_ff @(posedge clk) begin
        if (det_reset_s) begin
            hist_s     <= '0;
            det_seen_s <= 1'b0;
        end else begin
            hist_s     <= {hist_s[1:0], det_bit_s};
            det_seen_s <= ({hist_s, det_bit_s} == 4'b1011);
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to the next drive slot, 2 time units after the rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Round-robin rule: first valid index at or after the pointer, wrapping
    function automatic int model_grant(input logic [NUM_REQ-1:0] m);
        for (int i = 0; i < NUM_REQ; i++) begin
            int c;
            c = (rr_ptr_m + i) % NUM_REQ;
            if (m[c]) return c;
        end
        return -1;
    endfunction

    // Number of (overlapping) 1011 windows in the word, read MSB-first
    function automatic int ref_matches(input logic [WORD_W-1:0] w);
        int n;
        logic [3:0] win;
        n = 0;
        for (int s = 0; s + PAT_LEN <= WORD_W; s++) begin
            win = 4'(w >> (WORD_W - PAT_LEN - s));
            if (win == 4'b1011) n++;
        end
        return n;
    endfunction

    function automatic int sat(input int n, input int width);
        int mx;
        mx = (1 << width) - 1;
        return (n > mx) ? mx : n;
    endfunction

    // One full transaction starting in a drive slot where the DUT is idle
    task automatic do_txn(input logic [NUM_REQ-1:0] vmask, input logic [NUM_REQ*WORD_W-1:0] words,
                          input int hold, input bit keep);
        int g;
        int n;
        logic [WORD_W-1:0] w;
        logic exp_bit;
        req_valid = vmask;
        req_data  = words;
        res_ready = 1'b0;
        g = model_grant(vmask);
        w = words[g*WORD_W +: WORD_W];
        n = ref_matches(w);
        #1;
        chk("grant", 32'(req_ready), 32'(1) << g);
        chk("grant_sat", 32'(req_ready_s), 32'(1) << g);
        rr_ptr_m = (g + 1) % NUM_REQ;
        tick();
        if (!keep) req_valid = '0;
        res_ready = (hold == 0);
        for (int k = 1; k <= WORD_W + 2; k++) begin
            #1;
            chk("busy_ready", 32'(req_ready), 0);
            chk("busy_valid", 32'(res_valid), 0);
            chk("det_reset", 32'(det_reset), 32'(k == 1));
            exp_bit = (k >= 2 && k <= WORD_W + 1) ? w[WORD_W + 1 - k] : 1'b0;
            chk("det_bit", 32'(det_bit), 32'(exp_bit));
            tick();
        end
        #1;
        chk("res_valid", 32'(res_valid), 1);
        chk("res_id", 32'(res_id), 32'(g));
        chk("res_count", 32'(res_count), 32'(sat(n, CNT_W)));
        chk("res_valid_sat", 32'(res_valid_s), 1);
        chk("res_count_sat", 32'(res_count_s), 32'(sat(n, 1)));
        for (int h = 1; h <= hold; h++) begin
            tick();
            if (h == hold) res_ready = 1'b1;
            #1;
            chk("hold_valid", 32'(res_valid), 1);
            chk("hold_id", 32'(res_id), 32'(g));
            chk("hold_count", 32'(res_count), 32'(sat(n, CNT_W)));
            chk("hold_ready", 32'(req_ready), 0);
        end
        tick();
    endtask

    task automatic idle_gap(input int n);
        req_valid = '0;
        res_ready = 1'($urandom_range(0, 1));
        for (int i = 0; i < n; i++) begin
            #1;
            chk("idle_ready", 32'(req_ready), 0);
            chk("idle_valid", 32'(res_valid), 0);
            tick();
        end
    endtask

    initial begin
        int g;
        reset     = 1'b1;
        req_valid = '1;
        req_data  = '0;
        res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_res_id", 32'(res_id), 0);
        chk("rst_res_count", 32'(res_count), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_det_bit", 32'(det_bit), 0);
        chk("rst_det_reset", 32'(det_reset), 1);
        tick();
        reset     = 1'b0;
        req_valid = '0;

        // Held 0101 with ready consumer: grants alternate 0,2,0,2
        for (int i = 0; i < 4; i++)
            do_txn(4'b0101, {16'h0000, 16'hB6D0, 16'h0000, 16'hB000}, 0, 1'b1);

        // Single requesters with directed words
        do_txn(4'b0001, {48'h0, 16'hB000}, 0, 1'b0);
        do_txn(4'b0010, {32'h0, 16'hB6D0, 16'h0000}, 0, 1'b0);
        do_txn(4'b0010, {32'h0, 16'hFFFF, 16'h0000}, 0, 1'b0);

        // Backpressure: consumer stalls 10 cycles while others keep requesting
        do_txn(4'b1111, {16'h2D2D, 16'h5B5B, 16'h0B0B, 16'hB6D0}, 10, 1'b1);

        // Saturation of the 1-bit counter instance
        do_txn(4'b1000, {16'hBBBB, 48'h0}, 0, 1'b0);

        // Reset in the fifth SHIFT cycle, then a clean word
        req_valid = 4'b0010;
        req_data  = {32'h0, 16'hF800, 16'h0};
        res_ready = 1'b1;
        g = model_grant(4'b0010);
        #1;
        chk("abort_grant", 32'(req_ready), 32'(1) << g);
        repeat (6) tick();
        reset = 1'b1;
        #1;
        chk("mid_rst_res_valid", 32'(res_valid), 0);
        chk("mid_rst_det_reset", 32'(det_reset), 1);
        chk("mid_rst_req_ready", 32'(req_ready), 0);
        chk("mid_rst_det_bit", 32'(det_bit), 0);
        rr_ptr_m = 0;
        tick();
        reset = 1'b0;
        do_txn(4'b0010, {32'h0, 16'h6000, 16'h0}, 0, 1'b0);
        do_txn(4'b0010, {32'h0, 16'h0B0B, 16'h0}, 1, 1'b0);

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            logic [NUM_REQ-1:0] m;
            logic [NUM_REQ*WORD_W-1:0] d;
            m = NUM_REQ'($urandom_range(1, 15));
            d = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) idle_gap($urandom_range(1, 3));
            do_txn(m, d, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
